// File: rtl/radix4_seq_mul_8x8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radix4_seq_mul_8x8_pkg
// Description : Shared types and constants for the radix-4 sequential
//               8x8 multiplier: state encodings, radix-4 digit encodings
//               and step-counter sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package radix4_seq_mul_8x8_pkg;

    // Default operand width of the building block.
    localparam int WIDTH_DEFAULT = 8;

    // Number of radix-4 steps for the default width.
    localparam int STEPS = WIDTH_DEFAULT / 2;

    // Control state machine encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Plain-vector aliases of the state encoding, used by the FSM registers.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Radix-4 digit encodings: selects 0, 1x, 2x or 3x multiplicand.
    localparam logic [1:0] DIG_0  = 2'b00;
    localparam logic [1:0] DIG_1X = 2'b01;
    localparam logic [1:0] DIG_2X = 2'b10;
    localparam logic [1:0] DIG_3X = 2'b11;

    // Width of a counter that indexes 'steps' radix-4 steps (at least 1 bit).
    function automatic int cnt_width(input int steps);
        if (steps <= 2) begin
            return 1;
        end
        return $clog2(steps);
    endfunction

    // Step counter width for the default width.
    localparam int CNT_W = cnt_width(STEPS);

endpackage : radix4_seq_mul_8x8_pkg
`default_nettype wire

// File: rtl/radix4_seq_mul_8x8_pp_sel.sv
`default_nettype none
// ============================================================================
// Module      : pp_sel_radix4
// Description : Radix-4 partial-product selector. Maps a 2-bit multiplier
//               digit to 0, 1x, 2x or 3x of the multiplicand, zero-extended
//               to WIDTH+2 bits. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_sel_radix4
    import radix4_seq_mul_8x8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic [1:0]       d,
    output logic [WIDTH+1:0] pp
);

    logic [WIDTH+1:0] w_mcand_1x;
    logic [WIDTH+1:0] w_mcand_2x;
    logic [WIDTH+1:0] w_mcand_3x;

    // 1x and 2x are free wiring; 3x needs the single WIDTH+2 adder.
    assign w_mcand_1x = {2'b00, mcand};
    assign w_mcand_2x = {1'b0, mcand, 1'b0};
    assign w_mcand_3x = w_mcand_1x + w_mcand_2x;

    // Digit-driven selection of the partial product.
    always_comb begin
        pp = '0;
        case (d)
            DIG_0:   pp = '0;
            DIG_1X:  pp = w_mcand_1x;
            DIG_2X:  pp = w_mcand_2x;
            DIG_3X:  pp = w_mcand_3x;
            default: pp = '0;
        endcase
    end

endmodule : pp_sel_radix4
`default_nettype wire

// File: rtl/radix4_seq_mul_8x8.sv
`default_nettype none
// ============================================================================
// Module      : radix4_seq_mul_8x8
// Description : Sequential unsigned multiplier. Latches the operands, walks
//               the multiplier two bits per cycle for WIDTH/2 cycles and
//               accumulates shifted radix-4 partial products into a 2*WIDTH
//               product, then holds the result under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_seq_mul_8x8
    import radix4_seq_mul_8x8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     wi_mcand,
    input  logic [WIDTH-1:0]     wi_mplr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   wo_product,
    output logic                 busy
);

    localparam int         N_STEPS = WIDTH / 2;
    localparam int         K_W     = cnt_width(N_STEPS);
    localparam logic [K_W-1:0] K_LAST = K_W'(N_STEPS - 1);
    localparam int         PP_W    = WIDTH + 2;
    localparam int         PROD_W  = 2 * WIDTH;

    // Operand width must be even and at least 4 bits.
    generate
        if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("radix4_seq_mul_8x8: WIDTH must be even and >= 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [K_W-1:0]    k_q,     k_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplr_q,  mplr_d;
    logic [PROD_W-1:0] acc_q,   acc_d;

    // ------------------------------------------------------------------
    // Datapath: digit pick, partial product, shift into product position
    // ------------------------------------------------------------------
    logic [1:0]        w_digit;
    logic [PP_W-1:0]   w_pp;
    logic [PROD_W-1:0] w_pp_ext;
    logic [K_W:0]      w_shamt;
    logic [PROD_W-1:0] w_pp_shifted;
    logic [WIDTH-1:0]  w_mplr_shr;

    // Shift amount is 2k: step k weights its digit by 4^k.
    assign w_shamt      = {k_q, 1'b0};
    assign w_mplr_shr   = mplr_q >> w_shamt;
    assign w_digit      = w_mplr_shr[1:0];

    pp_sel_radix4 #(
        .WIDTH (WIDTH)
    ) u_pp_sel (
        .mcand (mcand_q),
        .d     (w_digit),
        .pp    (w_pp)
    );

    // Zero-extend to product width before shifting; the top bits never
    // carry out because the full product always fits in 2*WIDTH bits.
    assign w_pp_ext     = {{(PROD_W - PP_W){1'b0}}, w_pp};
    assign w_pp_shifted = w_pp_ext << w_shamt;

    // ------------------------------------------------------------------
    // Next-state logic: accept, accumulate WIDTH/2 steps, then hold result
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d = wi_mcand;
                    mplr_d  = wi_mplr;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + w_pp_shifted;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register update with synchronous active-low reset; a reset discards
    // any partial result so it is never presented.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, no input-to-output paths
    // ------------------------------------------------------------------
    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_RUN);
    assign wo_product = acc_q;

endmodule : radix4_seq_mul_8x8
`default_nettype wire
